// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM encoding, data width, bit-period helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - serial input synchronizer with falling-edge detect
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic s1, s2, s3;

    // Reset to 1 so an idle-high line never looks like a start bit after reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign dout = s2;
    assign fall = s3 & ~s2;

endmodule

// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - UART receiver, 8N1, LSB first, one-cycle done/frame-error strobes
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      uart_rxd,
    output logic                      uart_done,
    output logic [UART_DATA_BITS-1:0] uart_data,
    output logic                      uart_frame_err,
    output logic                      uart_rx_busy
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int HALF    = BPS_CNT / 2;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int IDX_W   = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    if (BPS_CNT < 4) begin : g_bps_check
        $error("uart_recv: CLK_FREQ/UART_BPS must be at least 4");
    end

    logic                      rxd_s;
    logic                      fall;
    uart_state_e               state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      mid;
    logic                      shift_en, start_ok, stop_ok, stop_bad;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (uart_rxd),
        .dout      (rxd_s),
        .fall      (fall)
    );

    // Bit-centre strobe: fires on the edge at which cnt advances to HALF.
    assign mid = (state != ST_IDLE) && (cnt == HALF_M1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fall) state_nxt = ST_START;
            ST_START: if (mid)  state_nxt = rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (mid && bit_idx == LAST_IDX) state_nxt = ST_STOP;
            ST_STOP:  if (mid)  state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_rx_busy = (state != ST_IDLE);
        start_ok     = 1'b0;
        shift_en     = 1'b0;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;
        case (state)
            ST_START: start_ok = mid && !rxd_s;
            ST_DATA:  shift_en = mid;
            ST_STOP: begin
                stop_ok  = mid && rxd_s;
                stop_bad = mid && !rxd_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            uart_data      <= '0;
            uart_done      <= 1'b0;
            uart_frame_err <= 1'b0;
        end else begin
            uart_done      <= stop_ok;
            uart_frame_err <= stop_bad;
            if (state == ST_IDLE || cnt == CNT_MAX) cnt <= '0;
            else                                    cnt <= cnt + 1'b1;
            if (start_ok) bit_idx <= '0;
            if (shift_en) begin
                shreg[bit_idx] <= rxd_s;
                bit_idx        <= bit_idx + 1'b1;
            end
            if (stop_ok) uart_data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - directed self-checking bench for uart_recv
module tb_uart_recv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       done_a, err_a, busy_a, done_b, err_b, busy_b;
    logic [7:0] data_a, data_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    time        t_a[$];
    int         err_cnt_a = 0, err_cnt_b = 0, busy_cnt_a = 0, both_hi = 0;
    time        ts_a = 0;

    always #5 clk = ~clk;

    uart_recv #(.CLK_FREQ(16), .UART_BPS(1)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_a),
        .uart_done(done_a), .uart_data(data_a),
        .uart_frame_err(err_a), .uart_rx_busy(busy_a)
    );

    uart_recv #(.CLK_FREQ(4), .UART_BPS(1)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_b),
        .uart_done(done_b), .uart_data(data_b),
        .uart_frame_err(err_b), .uart_rx_busy(busy_b)
    );

    always @(negedge clk) begin
        if (done_a) begin q_a.push_back(data_a); t_a.push_back($time); end
        if (done_b) q_b.push_back(data_b);
        if (err_a) err_cnt_a++;
        if (err_b) err_cnt_b++;
        if (busy_a) busy_cnt_a++;
        if ((done_a && err_a) || (done_b && err_b)) both_hi++;
    end

    task automatic clear_mon();
        q_a.delete(); q_b.delete(); t_a.delete();
        err_cnt_a = 0; err_cnt_b = 0; busy_cnt_a = 0;
    endtask

    task automatic drive_frame(input bit sel, input logic [7:0] b, input logic stop, input int bl);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (sel) rxd_b = fr[i];
            else     rxd_a = fr[i];
            if (i == 0 && !sel) ts_a = $time;
            repeat (bl - 1) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({done_a, err_a, busy_a, data_a} !== 11'd0) begin
            errors++; $display("FAIL reset_a: got %b/%b/%b/%h want 0/0/0/00", done_a, err_a, busy_a, data_a);
        end
        checks++;
        if ({done_b, err_b, busy_b, data_b} !== 11'd0) begin
            errors++; $display("FAIL reset_b: got %b/%b/%b/%h want 0/0/0/00", done_b, err_b, busy_b, data_b);
        end
    endtask

    task automatic test_single_byte();
        clear_mon();
        drive_frame(1'b0, 8'hA5, 1'b1, 16);
        repeat (20) @(posedge clk);
        checks++;
        if (q_a.size() !== 1) begin
            errors++; $display("FAIL single_count: got %0d want 1", q_a.size());
        end else begin
            checks++;
            if (q_a[0] !== 8'hA5) begin
                errors++; $display("FAIL single_data: got %h want a5", q_a[0]);
            end
            checks++;
            if (t_a[0] !== ts_a + 1554) begin
                errors++; $display("FAIL single_latency: got t=%0t want t=%0t", t_a[0], ts_a + 1554);
            end
        end
        checks++;
        if (err_cnt_a !== 0) begin
            errors++; $display("FAIL single_err: got %0d want 0", err_cnt_a);
        end
        checks++;
        if (data_a !== 8'hA5) begin
            errors++; $display("FAIL single_hold: got %h want a5", data_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [13];
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        clear_mon();
        for (int i = 0; i < 13; i++) drive_frame(1'b0, msg[i], 1'b1, 16);
        repeat (20) @(posedge clk);
        checks++;
        if (q_a.size() !== 13) begin
            errors++; $display("FAIL stream_count: got %0d want 13", q_a.size());
        end else begin
            for (int i = 0; i < 13; i++) begin
                checks++;
                if (q_a[i] !== msg[i]) begin
                    errors++; $display("FAIL stream_byte%0d: got %h want %h", i, q_a[i], msg[i]);
                end
            end
        end
        checks++;
        if (err_cnt_a !== 0) begin
            errors++; $display("FAIL stream_err: got %0d want 0", err_cnt_a);
        end
    endtask

    task automatic test_false_start();
        clear_mon();
        @(posedge clk); #1 rxd_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxd_a = 1'b1;
        repeat (40) @(posedge clk);
        checks++;
        if (busy_cnt_a < 1 || busy_cnt_a > 9) begin
            errors++; $display("FAIL false_busy_cycles: got %0d want 1..9", busy_cnt_a);
        end
        checks++;
        if (q_a.size() !== 0 || err_cnt_a !== 0) begin
            errors++; $display("FAIL false_pulses: got done=%0d err=%0d want 0/0", q_a.size(), err_cnt_a);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL false_idle: got busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        drive_frame(1'b0, 8'h3C, 1'b0, 16);
        repeat (40) @(posedge clk);
        #1 rxd_a = 1'b1;
        repeat (20) @(posedge clk);
        checks++;
        if (err_cnt_a !== 1) begin
            errors++; $display("FAIL ferr_count: got %0d want 1", err_cnt_a);
        end
        checks++;
        if (q_a.size() !== 0) begin
            errors++; $display("FAIL ferr_done: got %0d want 0", q_a.size());
        end
        checks++;
        if (data_a !== 8'h0A) begin
            errors++; $display("FAIL ferr_data_hold: got %h want 0a", data_a);
        end
        clear_mon();
        drive_frame(1'b0, 8'h55, 1'b1, 16);
        repeat (20) @(posedge clk);
        checks++;
        if (q_a.size() !== 1 || data_a !== 8'h55 || err_cnt_a !== 0) begin
            errors++; $display("FAIL ferr_recover: got n=%0d data=%h err=%0d want 1/55/0", q_a.size(), data_a, err_cnt_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        @(posedge clk); #1 rxd_a = 1'b0;
        repeat (15) @(posedge clk);
        #1 rxd_a = 1'b1;
        repeat (4 * 16 + 8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({done_a, err_a, busy_a, data_a} !== 11'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got %b/%b/%b/%h want 0/0/0/00", done_a, err_a, busy_a, data_a);
        end
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        checks++;
        if (q_a.size() !== 0 || err_cnt_a !== 0) begin
            errors++; $display("FAIL rst_mid_pulses: got done=%0d err=%0d want 0/0", q_a.size(), err_cnt_a);
        end
        drive_frame(1'b0, 8'h12, 1'b1, 16);
        repeat (20) @(posedge clk);
        checks++;
        if (q_a.size() !== 1 || data_a !== 8'h12) begin
            errors++; $display("FAIL rst_mid_next: got n=%0d data=%h want 1/12", q_a.size(), data_a);
        end
    endtask

    task automatic test_boundary();
        clear_mon();
        drive_frame(1'b1, 8'h00, 1'b1, 4);
        drive_frame(1'b1, 8'hFF, 1'b1, 4);
        repeat (10) @(posedge clk);
        checks++;
        if (q_b.size() !== 2) begin
            errors++; $display("FAIL bnd_count: got %0d want 2", q_b.size());
        end else begin
            checks++;
            if (q_b[0] !== 8'h00 || q_b[1] !== 8'hFF) begin
                errors++; $display("FAIL bnd_data: got %h %h want 00 ff", q_b[0], q_b[1]);
            end
        end
        checks++;
        if (err_cnt_b !== 0) begin
            errors++; $display("FAIL bnd_err: got %0d want 0", err_cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_reset_mid_frame();
        test_boundary();
        checks++;
        if (both_hi !== 0) begin
            errors++; $display("FAIL done_and_err_together: got %0d cycles want 0", both_hi);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
